// File: rtl/partition_err_monitor.sv
// partition_err_monitor
// Sweeps every input vector of a NUM_PI-input partition. It compares the exact
// and the approximate NUM_PO-bit responses and accumulates four error metrics:
// error count, Hamming-distance sum, error-distance sum and maximum error
// distance. Responses may arrive LAT cycles after their vector. A valid
// pipeline of the same depth keeps each response aligned with its vector.
module partition_err_monitor #(
  parameter int NUM_PI = 7,
  parameter int NUM_PO = 4,
  parameter int LAT    = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic [NUM_PI-1:0]                   pi,
  output logic                                pi_valid,
  input  logic [NUM_PO-1:0]                   po_exact,
  input  logic [NUM_PO-1:0]                   po_approx,
  output logic                                busy,
  output logic                                done,
  output logic [NUM_PI:0]                     err_count,
  output logic [NUM_PI+$clog2(NUM_PO+1)-1:0]  hd_sum,
  output logic [NUM_PI+NUM_PO-1:0]            ed_sum,
  output logic [NUM_PO-1:0]                   max_ed
);

  localparam int EC_W = NUM_PI + 1;
  localparam int PC_W = $clog2(NUM_PO + 1);
  localparam int HD_W = NUM_PI + PC_W;
  localparam int ED_W = NUM_PI + NUM_PO;
  localparam int D_W  = NUM_PO + 1;

  localparam logic [NUM_PI-1:0] LAST_VEC = '1;
  localparam logic [3:0]        LAT_M1   = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_PI-1:0]   cnt_q, cnt_d;
  logic [3:0]          drain_q, drain_d;
  logic                clear;
  logic                smp_vld;

  logic [EC_W-1:0]     err_q, err_d;
  logic [HD_W-1:0]     hd_q, hd_d;
  logic [ED_W-1:0]     ed_q, ed_d;
  logic [NUM_PO-1:0]   max_q, max_d;

  logic [D_W-1:0]      d_w;
  logic [PC_W-1:0]     pc_w;

  // Absolute difference, computed one bit wider so the subtraction cannot wrap.
  function automatic logic [D_W-1:0] abs_diff(input logic [NUM_PO-1:0] a,
                                               input logic [NUM_PO-1:0] b);
    logic [D_W-1:0] ea;
    logic [D_W-1:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  // Number of set bits in v.
  function automatic logic [PC_W-1:0] popcount(input logic [NUM_PO-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PO; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Control state: FSM, vector counter and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Next state. clear marks an accepted start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_VEC) begin
          drain_d = '0;
          if (LAT > 0) state_d = S_DRAIN;
          else         state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAT_M1) state_d = S_DONE;
        else                   drain_d = drain_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stimulus and status outputs, decoded from the registered state.
  always_comb begin
    pi_valid = (state_q == S_RUN);
    pi       = pi_valid ? cnt_q : '0;
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  // Delay pi_valid by LAT cycles so it lines up with the matching response.
  generate
    if (LAT == 0) begin : g_nolat
      assign smp_vld = pi_valid;
    end else begin : g_lat
      logic [LAT-1:0] vld_q;
      // Valid shift register. Reset flushes any response still in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= pi_valid;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
      assign smp_vld = vld_q[LAT-1];
    end
  endgenerate

  // Per-sample metrics. They are only consumed when smp_vld is high.
  always_comb begin
    d_w  = abs_diff(po_exact, po_approx);
    pc_w = popcount(po_exact ^ po_approx);
  end

  // Accumulator next values: cleared on an accepted start, updated on a valid sample.
  always_comb begin
    err_d = err_q;
    hd_d  = hd_q;
    ed_d  = ed_q;
    max_d = max_q;
    if (clear) begin
      err_d = '0;
      hd_d  = '0;
      ed_d  = '0;
      max_d = '0;
    end else if (smp_vld) begin
      err_d = err_q + EC_W'(d_w != '0);
      hd_d  = hd_q + HD_W'(pc_w);
      ed_d  = ed_q + ED_W'(d_w);
      if (d_w > {1'b0, max_q}) max_d = d_w[NUM_PO-1:0];
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      hd_q  <= '0;
      ed_q  <= '0;
      max_q <= '0;
    end else begin
      err_q <= err_d;
      hd_q  <= hd_d;
      ed_q  <= ed_d;
      max_q <= max_d;
    end
  end

  assign err_count = err_q;
  assign hd_sum    = hd_q;
  assign ed_sum    = ed_q;
  assign max_ed    = max_q;

endmodule
